device_mailbox: RTL
===================

// Module: device_mailbox
// PURPOSE
//  Device-space responder on the cluster device bus (addr[15:10]==6'b111111 upstream).
//  Decodes one device request per cycle, tagged with the issuing core's id.
//  Provides one hardware FIFO inbox per core, used for inter-core message passing.
//  Returns read data registered, one cycle after the request, matching the cluster's
//  latched read-data mux.
// PARAMETERS
//  NUM_CORES   8   number of cores/inboxes; core id width is fixed at 3 bits
//  FIFO_DEPTH  4   entries per inbox; power of two, 2..8
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high
//  device_core_id   in   3   id of the core issuing the current request
//  device_write_en  in   1   write strobe for the current cycle
//  device_read_en   in   1   read strobe for the current cycle
//  device_addr      in   10  register offset within device space
//  device_data_out  in   16  write data from cluster
//  device_data_in   out  16  registered read data to cluster
//  inbox_nonempty   out  NUM_CORES  bit n=1 when inbox n holds >=1 message
// BEHAVIOUR
//  Register map (offset, access):
//   0x000 DEST W: dest[core_id] <= data[2:0]; upper bits ignored. Reads return 0.
//   0x001 SEND W: push data into inbox[dest[core_id]]. Sending to self is legal.
//                 If the target inbox is full: drop data, set ovf[core_id].
//   0x002 RECV R: own inbox nonempty -> return head, pop. Empty -> return 0, no pop.
//   0x003 STAT R: [3:0]=own inbox count; [8]=own inbox full;
//                 [14]=inbox[dest[core_id]] full; [15]=ovf[core_id]; other bits 0.
//                 Read clears ovf[core_id], except when set in the same cycle.
//  Unmapped offsets: reads return 0; writes ignored.
//  write_en and read_en both high in one cycle: the write is performed; read data is 0.
//  Read latency:
//   - device_data_in updates on the clk edge that samples read_en.
//   - It holds its value until the next read.
//   - Writes do not change it.
//  Side effects (push, pop, ovf clear) commit on that same edge.
//   - A STAT read in the following cycle reflects them.
//  Arbitration: at most one request per cycle, so push and pop never occur together.
//  Inbox storage:
//   - Per-core circular buffer, FIFO_DEPTH x 16 bits.
//   - rd_ptr and wr_ptr each have log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//   - count has log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
//  Full means count==FIFO_DEPTH; empty means count==0. Strict FIFO order across wrap.
//  inbox_nonempty is combinational from the counts.
//  Reset (async, any time, including mid-transfer):
//   - All pointers and counts go to 0; all dest go to 0; all ovf go to 0.
//   - device_data_in goes to 16'h0000; inbox_nonempty goes to 0.
//   - Queued messages are discarded. Storage contents need not be cleared.
// TESTING
//  1 After reset: STAT read by core 0 -> 16'h0000; RECV read -> 16'h0000;
//    inbox_nonempty==8'h00.
//  2 Core1 writes DEST=3, then SEND 16'hBEEF -> inbox_nonempty[3]=1.
//    Core3 STAT -> 16'h0001; core3 RECV -> 16'hBEEF, valid the cycle after the request.
//    Core3 STAT -> 16'h0000.
//  3 Core2 with DEST=5 sends 16'h0011..16'h0014 -> core5 STAT==16'h0104.
//    5th send 16'h0015 -> core2 STAT==16'hC000, then 16'h4000 on re-read.
//    Core5 RECV x5 -> 0011, 0012, 0013, 0014, 0000.
//  4 Wrap: core0 self-sends; 10 alternating SEND/RECV pairs with values 1..10
//    -> each RECV returns the value just sent. Then 3 sends + 3 receives
//    -> order preserved across pointer wrap.
//  5 Offset 0x3FF: read -> 0, no state change. Write 16'hFFFF -> no state change.
//    Simultaneous write_en+read_en on SEND -> push occurs, device_data_in==0.
//  6 Core4 queues 2 messages to core6; reset pulsed mid-cycle
//    -> device_data_in==0 immediately, inbox_nonempty==0.
//    Core6 RECV -> 0; core4 DEST reads back as target 0 (send lands in inbox 0).

Source files
------------

// File: rtl/device_mailbox.sv
// Device-space mailbox: one hardware FIFO inbox per core for inter-core messages.
// Read data is registered and returned one cycle after the request.
module device_mailbox #(
    parameter int NUM_CORES  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           device_core_id,
    input  logic                 device_write_en,
    input  logic                 device_read_en,
    input  logic [9:0]           device_addr,
    input  logic [15:0]          device_data_out,
    output logic [15:0]          device_data_in,
    output logic [NUM_CORES-1:0] inbox_nonempty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [9:0] A_DEST = 10'h000;
    localparam logic [9:0] A_SEND = 10'h001;
    localparam logic [9:0] A_RECV = 10'h002;
    localparam logic [9:0] A_STAT = 10'h003;

    logic [15:0]          mem_q    [NUM_CORES][FIFO_DEPTH];
    logic [15:0]          mem_d    [NUM_CORES][FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr_q [NUM_CORES];
    logic [PW-1:0]        rd_ptr_d [NUM_CORES];
    logic [PW-1:0]        wr_ptr_q [NUM_CORES];
    logic [PW-1:0]        wr_ptr_d [NUM_CORES];
    logic [CW-1:0]        count_q  [NUM_CORES];
    logic [CW-1:0]        count_d  [NUM_CORES];
    logic [2:0]           dest_q   [NUM_CORES];
    logic [2:0]           dest_d   [NUM_CORES];
    logic [NUM_CORES-1:0] ovf_q;
    logic [NUM_CORES-1:0] ovf_d;
    logic [15:0]          rdata_q;
    logic [15:0]          rdata_d;

    logic                 wr;
    logic                 rd;
    logic [2:0]           id;
    logic [2:0]           tgt;
    logic [CW-1:0]        own_cnt;
    logic                 own_full;
    logic                 tgt_full;
    logic [15:0]          stat;

    always_comb begin
        id       = device_core_id;
        wr       = device_write_en;
        // A write wins over a simultaneous read; the read then returns 0.
        rd       = device_read_en & ~device_write_en;
        tgt      = dest_q[id];
        own_cnt  = count_q[id];
        own_full = (own_cnt == CW'(FIFO_DEPTH));
        tgt_full = (count_q[tgt] == CW'(FIFO_DEPTH));
        stat           = '0;
        stat[CW-1:0]   = own_cnt;
        stat[8]        = own_full;
        stat[14]       = tgt_full;
        stat[15]       = ovf_q[id];
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dest_d   = dest_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;

        if (device_read_en) begin
            rdata_d = '0;
        end

        if (wr) begin
            case (device_addr)
                A_DEST: begin
                    dest_d[id] = device_data_out[2:0];
                end
                A_SEND: begin
                    if (tgt_full) begin
                        ovf_d[id] = 1'b1;
                    end else begin
                        mem_d[tgt][wr_ptr_q[tgt]] = device_data_out;
                        wr_ptr_d[tgt] = wr_ptr_q[tgt] + PW'(1);
                        count_d[tgt]  = count_q[tgt] + CW'(1);
                    end
                end
                default: ;
            endcase
        end else if (rd) begin
            case (device_addr)
                A_RECV: begin
                    if (own_cnt != '0) begin
                        rdata_d      = mem_q[id][rd_ptr_q[id]];
                        rd_ptr_d[id] = rd_ptr_q[id] + PW'(1);
                        count_d[id]  = own_cnt - CW'(1);
                    end
                end
                A_STAT: begin
                    rdata_d   = stat;
                    ovf_d[id] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                dest_q[i]   <= '0;
            end
            ovf_q   <= '0;
            rdata_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dest_q   <= dest_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

    // Message storage is not reset; counts and pointers alone define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int n = 0; n < NUM_CORES; n++) begin
            inbox_nonempty[n] = (count_q[n] != '0);
        end
    end

    assign device_data_in = rdata_q;

endmodule
